// File: rtl/chiplet_types_pkg.sv
// rtl/chiplet_types_pkg.sv - shared flit, credit and transmitter-state types for the switch
// Contents:
//   flit_t              crossbar/link flit; payload low bits carry the packet length in flits
//   PKT_LENGTH_WIDTH    width of the packet-length field
//   expected_num_flits  packet length (in flits) decoded from a head-flit payload
//   credit_t            per-VC credit count sized for TX_DEPTH
//   tx_state_t          wormhole tracking state of the output-port transmitter
package chiplet_types_pkg;

    localparam int PKT_LENGTH_WIDTH   = 4;
    localparam int FLIT_PAYLOAD_WIDTH = 32;

    typedef struct packed {
        logic [FLIT_PAYLOAD_WIDTH-1:0] payload;
    } flit_t;

    localparam int TX_DEPTH     = 8;
    localparam int CREDIT_WIDTH = $clog2(TX_DEPTH + 1);

    typedef logic [CREDIT_WIDTH-1:0] credit_t;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } tx_state_t;

    // Only the head flit's length field matters here; the rest of the payload
    // is opaque data carried along the link.
    function automatic logic [PKT_LENGTH_WIDTH-1:0] expected_num_flits(
        input logic [FLIT_PAYLOAD_WIDTH-1:0] payload
    );
        logic unused_payload_bits;
        unused_payload_bits = ^payload[FLIT_PAYLOAD_WIDTH-1:PKT_LENGTH_WIDTH];
        return payload[PKT_LENGTH_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/switch_outport_tx_credit_counter.sv
// rtl/switch_outport_tx_credit_counter.sv - per-VC downstream buffer credit counter
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   consume        a flit was accepted on this VC (ignored when count is 0)
//   credit_return  one-cycle pulse restoring CREDIT_BATCH credits
//   count          current credit count, reset to DEPTH
//   err            sticky: a return would have pushed the count above DEPTH
module switch_credit_counter #(
    parameter int DEPTH        = 8,
    parameter int CREDIT_BATCH = 3 * DEPTH / 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         consume,
    input  logic                         credit_return,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_count;
    logic          r_err;
    logic          w_take;
    logic [CW:0]   w_sum;
    logic          w_over;

    // Guarding the decrement here keeps the count from ever wrapping below 0.
    assign w_take = consume && (r_count != '0);

    // One extra bit so count + batch cannot wrap before the saturation test.
    always_comb begin
        w_sum  = {1'b0, r_count}
               + (credit_return ? (CW+1)'(CREDIT_BATCH) : '0)
               - (CW+1)'(w_take);
        w_over = w_sum > (CW+1)'(DEPTH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= CW'(DEPTH);
            r_err   <= 1'b0;
        end else begin
            r_count <= w_over ? CW'(DEPTH) : w_sum[CW-1:0];
            if (w_over) begin
                r_err <= 1'b1;
            end
        end
    end

    assign count = r_count;
    assign err   = r_err;

endmodule

// File: rtl/switch_outport_tx.sv
// rtl/switch_outport_tx.sv - credit-based output-port transmitter with wormhole VC locking
// Optional feature macro: SWITCH_TX_STATS_EN (adds stat_flits, stat_credit_stalls)
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   in_valid/in_flit/in_vc/in_ready   crossbar side; accept when in_valid && in_ready
//   out_valid/out_flit/out_vc/out_ready  registered link side
//   credit_return       per-VC pulse, each restores CREDIT_BATCH credits
//   credits             per-VC current credit counts
//   pkt_done            one-cycle pulse the cycle after a tail flit is accepted
//   credit_err          sticky credit overflow flag
//   stat_flits, stat_credit_stalls  (SWITCH_TX_STATS_EN only) wrapping 32-bit counters
module switch_outport_tx
    import chiplet_types_pkg::*;
#(
    parameter int NUM_VCS      = 2,
    parameter int DEPTH        = 8,
    parameter int CREDIT_BATCH = 3 * DEPTH / 4
) (
    input  logic                                         CLK,
    input  logic                                         RST,
    input  logic                                         in_valid,
    input  flit_t                                        in_flit,
    input  logic [$clog2(NUM_VCS)-1:0]                   in_vc,
    output logic                                         in_ready,
    output logic                                         out_valid,
    output flit_t                                        out_flit,
    output logic [$clog2(NUM_VCS)-1:0]                   out_vc,
    input  logic                                         out_ready,
    input  logic [NUM_VCS-1:0]                           credit_return,
    output logic [NUM_VCS-1:0][$clog2(DEPTH+1)-1:0]      credits,
    output logic                                         pkt_done,
`ifdef SWITCH_TX_STATS_EN
    output logic [31:0]                                  stat_flits,
    output logic [31:0]                                  stat_credit_stalls,
`endif
    output logic                                         credit_err
);

    localparam int VCW = $clog2(NUM_VCS);
    localparam int CW  = $clog2(DEPTH + 1);

    tx_state_t                      r_state, w_state_next;
    logic [PKT_LENGTH_WIDTH-1:0]    r_remaining, w_remaining_next;
    logic [VCW-1:0]                 r_lock_vc, w_lock_vc_next;
    logic                           r_pkt_done, w_pkt_done_next;

    logic                           r_out_valid;
    flit_t                          r_out_flit;
    logic [VCW-1:0]                 r_out_vc;

    logic [VCW-1:0]                 w_eff_vc;
    logic                           w_accept;
    logic                           w_eff_has_credit;
    logic [PKT_LENGTH_WIDTH-1:0]    w_len;
    logic [NUM_VCS-1:0]             w_consume;
    logic [NUM_VCS-1:0]             w_err;
    logic [NUM_VCS-1:0][CW-1:0]     w_credits;

    // Once a head flit has gone out, the rest of the packet must follow on the
    // same VC regardless of what VC allocation presents.
    assign w_eff_vc         = (r_state == BODY) ? r_lock_vc : in_vc;
    assign w_eff_has_credit = (w_credits[w_eff_vc] != '0);
    assign in_ready         = (!r_out_valid || out_ready) && w_eff_has_credit;
    assign w_accept         = in_valid && in_ready;
    assign w_len            = expected_num_flits(in_flit.payload);

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        assign w_consume[v] = w_accept && (w_eff_vc == VCW'(v));

        switch_credit_counter #(
            .DEPTH        (DEPTH),
            .CREDIT_BATCH (CREDIT_BATCH)
        ) u_credit (
            .CLK           (CLK),
            .RST           (RST),
            .consume       (w_consume[v]),
            .credit_return (credit_return[v]),
            .count         (w_credits[v]),
            .err           (w_err[v])
        );
    end

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_lock_vc_next   = r_lock_vc;
        w_pkt_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // Lengths 0 and 1 are both a self-contained single-flit packet.
                    if (w_len <= PKT_LENGTH_WIDTH'(1)) begin
                        w_pkt_done_next = 1'b1;
                    end else begin
                        w_remaining_next = w_len - PKT_LENGTH_WIDTH'(1);
                        w_lock_vc_next   = in_vc;
                        w_state_next     = BODY;
                    end
                end
            end
            BODY: begin
                if (w_accept) begin
                    if (r_remaining == PKT_LENGTH_WIDTH'(1)) begin
                        w_pkt_done_next  = 1'b1;
                        w_remaining_next = '0;
                        w_state_next     = IDLE;
                    end else begin
                        w_remaining_next = r_remaining - PKT_LENGTH_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_lock_vc   <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_lock_vc   <= w_lock_vc_next;
            r_pkt_done  <= w_pkt_done_next;
        end
    end

    // Single link register: in_ready already folds in out_ready, so a load
    // never overwrites a flit the sink has not taken.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_vc    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_flit  <= in_flit;
            r_out_vc    <= w_eff_vc;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef SWITCH_TX_STATS_EN
    logic [31:0] r_stat_flits;
    logic [31:0] r_stat_credit_stalls;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_flits         <= '0;
            r_stat_credit_stalls <= '0;
        end else begin
            if (w_accept) begin
                r_stat_flits <= r_stat_flits + 32'd1;
            end
            if (in_valid && !in_ready && !w_eff_has_credit) begin
                r_stat_credit_stalls <= r_stat_credit_stalls + 32'd1;
            end
        end
    end

    assign stat_flits         = r_stat_flits;
    assign stat_credit_stalls = r_stat_credit_stalls;
`endif

    assign out_valid  = r_out_valid;
    assign out_flit   = r_out_flit;
    assign out_vc     = r_out_vc;
    assign credits    = w_credits;
    assign pkt_done   = r_pkt_done;
    assign credit_err = |w_err;

endmodule

// File: tb/tb_switch_outport_tx.sv
// tb/tb_switch_outport_tx.sv - randomized and directed bench for switch_outport_tx against a packet-level model
module tb_switch_outport_tx;
    import chiplet_types_pkg::*;

    localparam int NUM_VCS = 2;
    localparam int DEPTH   = 8;
    localparam int BATCH   = 3 * DEPTH / 4;

    logic                        CLK;
    logic                        RST;
    logic                        in_valid;
    flit_t                       in_flit;
    logic [0:0]                  in_vc;
    logic                        in_ready;
    logic                        out_valid;
    flit_t                       out_flit;
    logic [0:0]                  out_vc;
    logic                        out_ready;
    logic [NUM_VCS-1:0]          credit_return;
    logic [NUM_VCS-1:0][3:0]     credits;
    logic                        pkt_done;
    logic                        credit_err;
`ifdef SWITCH_TX_STATS_EN
    logic [31:0]                 stat_flits;
    logic [31:0]                 stat_credit_stalls;
`endif

    switch_outport_tx #(
        .NUM_VCS      (NUM_VCS),
        .DEPTH        (DEPTH),
        .CREDIT_BATCH (BATCH)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_valid      (in_valid),
        .in_flit       (in_flit),
        .in_vc         (in_vc),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_flit      (out_flit),
        .out_vc        (out_vc),
        .out_ready     (out_ready),
        .credit_return (credit_return),
        .credits       (credits),
        .pkt_done      (pkt_done),
`ifdef SWITCH_TX_STATS_EN
        .stat_flits         (stat_flits),
        .stat_credit_stalls (stat_credit_stalls),
`endif
        .credit_err    (credit_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks;
    int n_errors;

    // Packet-level model: credits as plain integers, a packet as "flits still owed".
    int    m_cred [NUM_VCS];
    bit    m_err;
    bit    m_ov;
    flit_t m_oflit;
    int    m_ovc;
    bit    m_pd;
    bit    m_in_pkt;
    int    m_left;
    int    m_lock;
    int    m_flits;
    int    m_stalls;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NUM_VCS; v++) m_cred[v] = DEPTH;
        m_err    = 1'b0;
        m_ov     = 1'b0;
        m_oflit  = '0;
        m_ovc    = 0;
        m_pd     = 1'b0;
        m_in_pkt = 1'b0;
        m_left   = 0;
        m_lock   = 0;
        m_flits  = 0;
        m_stalls = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_ov);
        check("out_vc", out_vc, m_ovc);
        check("out_flit", out_flit, m_oflit);
        check("credits0", credits[0], m_cred[0]);
        check("credits1", credits[1], m_cred[1]);
        check("pkt_done", pkt_done, m_pd);
        check("credit_err", credit_err, m_err);
`ifdef SWITCH_TX_STATS_EN
        check("stat_flits", stat_flits, m_flits);
        check("stat_credit_stalls", stat_credit_stalls, m_stalls);
`endif
    endtask

    function automatic flit_t mk_flit(input int len);
        flit_t f;
        f.payload      = $urandom();
        f.payload[3:0] = len[3:0];
        return f;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST           = 1'b1;
        in_valid      = 1'b0;
        in_vc         = '0;
        in_flit       = '0;
        out_ready     = 1'b0;
        credit_return = '0;
        @(posedge CLK);
        #1;
        model_reset();
        check_outputs();
        check("in_ready_rst", in_ready, 1'b1);
    endtask

    task automatic step(input bit v, input int vc, input flit_t f, input bit ordy, input bit [1:0] cret);
        int  eff;
        bit  exp_rdy;
        bit  acc;
        int  len;
        int  c;
        @(negedge CLK);
        RST           = 1'b0;
        in_valid      = v;
        in_vc         = vc[0:0];
        in_flit       = f;
        out_ready     = ordy;
        credit_return = cret;
        #1;
        eff     = m_in_pkt ? m_lock : vc;
        exp_rdy = (!m_ov || ordy) && (m_cred[eff] > 0);
        check("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        len = int'(f.payload[3:0]);

        m_pd = 1'b0;
        if (acc) begin
            m_flits++;
            if (!m_in_pkt) begin
                if (len <= 1) begin
                    m_pd = 1'b1;
                end else begin
                    m_in_pkt = 1'b1;
                    m_left   = len - 1;
                    m_lock   = vc;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_in_pkt = 1'b0;
                    m_pd     = 1'b1;
                end
            end
        end
        if (v && !exp_rdy && m_cred[eff] == 0) m_stalls++;

        for (int i = 0; i < NUM_VCS; i++) begin
            c = m_cred[i] - ((acc && eff == i) ? 1 : 0) + (cret[i] ? BATCH : 0);
            if (c > DEPTH) begin
                c     = DEPTH;
                m_err = 1'b1;
            end
            m_cred[i] = c;
        end

        if (acc) begin
            m_ov    = 1'b1;
            m_oflit = f;
            m_ovc   = eff;
        end else if (ordy) begin
            m_ov = 1'b0;
        end

        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, 1'b1, 2'b00);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();

        // Reset then idle.
        do_reset();
        idle(2);

        // 3-flit packet on VC1.
        step(1'b1, 1, mk_flit(3), 1'b1, 2'b00);
        step(1'b1, 1, mk_flit(0), 1'b1, 2'b00);
        step(1'b1, 1, mk_flit(0), 1'b1, 2'b00);
        idle(2);
        check("credits1_after_pkt", credits[1], 5);

        // Nine single-flit packets on VC0: the ninth stalls on credits.
        for (int i = 0; i < 9; i++) step(1'b1, 0, mk_flit(1), 1'b1, 2'b00);
        check("credits0_empty", credits[0], 0);
        step(1'b1, 0, mk_flit(1), 1'b1, 2'b01);
        check("credits0_returned", credits[0], 6);
        step(1'b1, 0, mk_flit(1), 1'b1, 2'b00);
        check("credits0_after_ninth", credits[0], 5);

        // Link backpressure with a flit registered.
        step(1'b1, 0, mk_flit(1), 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) step(1'b1, 0, mk_flit(1), 1'b0, 2'b00);
        step(1'b1, 0, mk_flit(1), 1'b1, 2'b00);
        idle(1);

        // Same-cycle consume and return, then saturation.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 0, mk_flit(1), 1'b1, 2'b00);
        step(1'b1, 0, mk_flit(1), 1'b1, 2'b01);
        check("credits0_net", credits[0], 7);
        step(1'b1, 0, mk_flit(1), 1'b1, 2'b00);
        step(1'b1, 0, mk_flit(1), 1'b1, 2'b00);
        step(1'b0, 0, '0, 1'b1, 2'b01);
        check("credits0_sat", credits[0], 8);
        idle(100);
        check("credit_err_sticky", credit_err, 1'b1);

        // VC lock in BODY, then reset mid-packet.
        do_reset();
        step(1'b1, 0, mk_flit(4), 1'b1, 2'b00);
        step(1'b1, 1, mk_flit(0), 1'b1, 2'b00);
        check("locked_out_vc", out_vc, 1'b0);
        do_reset();
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 1)),
                     mk_flit(int'($urandom_range(0, 4))),
                     $urandom_range(0, 3) != 0,
                     {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
